// File: rtl/fft_unloader.sv
// ============================================================================
// Module   : fft_unloader
// Brief    : Streams an N-point FFT result from RAM in natural frequency order.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_unloader #(
  parameter int LOG2N  = 10,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fft_ok,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_data_i,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              busy,
  output logic              done
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N:0]   c_last_rd  = (LOG2N+1)'(N-1);
  localparam logic [LOG2N-1:0] c_last_out = LOG2N'(N-1);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_read  = 2'd1;
  localparam logic [1:0] c_drain = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic              r_fft_ok_q;
  logic              w_start;
  logic [LOG2N:0]    r_rd_cnt;
  logic              r_rd_pend;
  logic [ADDR_W-1:0] r_addr_hold;
  logic [LOG2N-1:0]  w_rev;
  logic [ADDR_W-1:0] w_addr_cur;
  logic              w_rd_en;
  logic              w_busy;
  logic [DATA_W-1:0] r_mem [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;
  logic [2:0]        w_occ;
  logic              w_push;
  logic              w_pop;
  logic [LOG2N-1:0]  r_out_cnt;
  logic              r_done;
  logic              w_last;

  assign w_start = (r_state == c_idle) && fft_ok && !r_fft_ok_q;

  generate
    for (genvar i = 0; i < LOG2N; i++) begin : g_bitrev
      assign w_rev[i] = r_rd_cnt[LOG2N-1-i];
    end
  endgenerate

  assign w_addr_cur = ADDR_W'(w_rev);

  assign w_push = r_rd_pend;
  assign w_pop  = (r_count != 2'd0) && dout_ready;
  assign w_last = (r_count != 2'd0) && (r_out_cnt == c_last_out);
  // Slots already committed: stored entries plus the read whose data lands next edge.
  assign w_occ  = {1'b0, r_count} + {2'b00, r_rd_pend} - {2'b00, w_pop};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle:  if (w_start) w_next_state = c_read;
      c_read:  if (w_rd_en && (r_rd_cnt == c_last_rd)) w_next_state = c_drain;
      c_drain: if (w_pop && w_last) w_next_state = c_idle;
      default: w_next_state = c_idle;
    endcase
  end

  // Output logic
  always_comb begin
    w_rd_en = 1'b0;
    w_busy  = 1'b1;
    case (r_state)
      c_idle:  w_busy  = 1'b0;
      c_read:  w_rd_en = !r_rd_cnt[LOG2N] && (w_occ < 3'd2);
      default: w_rd_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fft_ok_q  <= 1'b0;
      r_rd_cnt    <= '0;
      r_rd_pend   <= 1'b0;
      r_addr_hold <= '0;
      r_out_cnt   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_fft_ok_q <= fft_ok;
      r_rd_pend  <= w_rd_en;
      r_done     <= (r_state == c_drain) && w_pop && w_last;
      if (w_start) begin
        r_rd_cnt  <= '0;
        r_out_cnt <= '0;
      end else begin
        if (w_rd_en) begin
          r_rd_cnt    <= r_rd_cnt + 1'b1;
          r_addr_hold <= w_addr_cur;
        end
        if (w_pop) begin
          r_out_cnt <= r_out_cnt + 1'b1;
        end
      end
    end
  end

  // Two-entry skid FIFO holding returned read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= ram_data_i;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign ram_rd_en  = w_rd_en;
  assign ram_addr   = w_rd_en ? w_addr_cur : r_addr_hold;
  assign dout       = r_mem[r_rptr];
  assign dout_valid = (r_count != 2'd0);
  assign dout_last  = w_last;
  assign busy       = w_busy;
  assign done       = r_done;

endmodule

`default_nettype wire

// File: doc/fft_unloader.md
FFT_UNLOADER -- requirements
Module: fft_unloader

Interface
REQ-001 Parameter LOG2N, default 10, transform size exponent (N = 1024 points).
REQ-002 Parameter ADDR_W, default 16, sample RAM address width.
REQ-003 Parameter DATA_W, default 64, complex sample width ({imag[31:0], real[31:0]}).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 fft_ok  input  1  level from FFT core; transform complete and results resident in RAM.
REQ-007 ram_rd_en  output  1  RAM read request.
REQ-008 ram_addr  output  ADDR_W  RAM read address.
REQ-009 ram_data_i  input  DATA_W  RAM read data, valid exactly 1 cycle after a ram_rd_en cycle.
REQ-010 dout  output  DATA_W  streamed result sample.
REQ-011 dout_valid  output  1  dout holds a sample.
REQ-012 dout_ready  input  1  downstream accepts; beat transfers when dout_valid & dout_ready at a rising edge.
REQ-013 dout_last  output  1  high with the beat of index N-1.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse after the final beat transfers.

Function
REQ-016 The block SHALL register fft_ok and start an unload only on a rising edge (fft_ok=1, previous sample 0) seen in IDLE.
REQ-017 States SHALL be IDLE, READ, DRAIN, with IDLE->READ on the start edge, READ->DRAIN after the read for index N-1 issues, and DRAIN->IDLE when the beat with dout_last transfers.
REQ-018 Output index k (0..N-1) SHALL be read from ram_addr = zero-extended bit-reverse of k over LOG2N bits, so output order is natural frequency order.
REQ-019 The read counter SHALL be LOG2N+1 bits wide, so index N-1 is reached without wrapping to 0.
REQ-020 Returning read data SHALL be captured into a 2-entry FIFO; dout/dout_valid SHALL come from the FIFO head.
REQ-021 ram_rd_en SHALL assert in READ only when (FIFO occupancy + reads in flight - pop this cycle) < 2, so no datum is ever lost.
REQ-022 ram_addr SHALL hold its last value while ram_rd_en is low.
REQ-023 With dout_ready held high, throughput SHALL be one beat per cycle with no bubbles after the first beat.
REQ-024 Latency: for a start edge detected at rising edge E, ram_rd_en SHALL be high in the cycle after E, and dout_valid SHALL rise at edge E+2.
REQ-025 dout and dout_last SHALL stay stable while dout_valid=1 and dout_ready=0.
REQ-026 dout_last SHALL be high only with beat N-1 and low otherwise.
REQ-027 done SHALL pulse high for exactly one cycle, in the cycle after the dout_last transfer, coincident with the return to IDLE.
REQ-028 fft_ok edges arriving while busy=1 SHALL be ignored and not queued.
REQ-029 If fft_ok is already high when the unload finishes, no new unload SHALL start until fft_ok falls and rises again.
REQ-030 dout_ready asserted while dout_valid=0 SHALL have no effect.

Reset
REQ-031 Asserting rst_n low SHALL immediately clear the state to IDLE and the FIFO to empty, and drive ram_rd_en, dout_valid, dout_last, busy and done to 0, ram_addr to 0 and dout to 0.
REQ-032 Reset mid-unload SHALL abort the unload without resuming, and the registered fft_ok history SHALL clear to 0, so that fft_ok held high through reset release starts a new unload on the first edge.

Verification
REQ-033 Ready always high, fft_ok rises -> ram_addr sequence 0,512,256,768,128...; 1024 beats on consecutive cycles; dout_last on beat 1023; done one cycle later.
REQ-034 RAM preloaded with mem[a]=a, ready always high -> dout equals bitrev10(k) for every k; no duplicates; no gaps.
REQ-035 Random dout_ready (50%) -> all 1024 beats delivered in order, dout stable while stalled, at most 2 reads outstanding beyond accepted beats.
REQ-036 dout_ready low for 20 cycles right after the first valid -> ram_rd_en stops after 2 reads; resumes correctly and no data is lost.
REQ-037 fft_ok toggled again at beat 300 -> ignored; exactly 1024 beats and a single done pulse.
REQ-038 rst_n pulsed low at beat 500 -> all outputs 0 at once; after release with fft_ok high, a fresh unload restarts from index 0.
